// File: rtl/tamagotchi_button_ctrl_if.sv
// Raw push-button inputs and conditioned button outputs for tamagotchi_button_ctrl.
// The master drives the raw buttons; the slave (the conditioner) drives the pulses and hold counts.
interface tamagotchi_button_ctrl_if;
  logic       raw_salud_n;
  logic       raw_energia_n;
  logic       raw_hambre_n;
  logic       raw_diversion_n;
  logic       raw_reset_n;
  logic       raw_test_n;
  logic       btn_salud;
  logic       btn_energia;
  logic       btn_hambre;
  logic       btn_diversion;
  logic       btn_reset;
  logic       btn_test;
  logic [2:0] count_reset;
  logic [2:0] count_test;

  modport master (
    output raw_salud_n, raw_energia_n, raw_hambre_n, raw_diversion_n, raw_reset_n, raw_test_n,
    input  btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
    input  count_reset, count_test
  );

  modport slave (
    input  raw_salud_n, raw_energia_n, raw_hambre_n, raw_diversion_n, raw_reset_n, raw_test_n,
    output btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test,
    output count_reset, count_test
  );
endinterface

// File: rtl/tamagotchi_button_ctrl.sv
// Button conditioner: 2-flop sync + debounce per button, press pulses after DEBOUNCE_CYCLES+2 edges,
// whole-second hold counters for reset/test. No backpressure: pulses are single-cycle and fire-and-forget.
module tamagotchi_button_ctrl #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_SEC        = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tamagotchi_button_ctrl_if.slave   bif
);
  localparam int SCW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DC_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(CLK_FREQ_HZ - 1);
  localparam logic [2:0]     HOLD_MAX = 3'(HOLD_SEC);

  // Bit order: salud, energia, hambre, diversion, reset, test.
  logic [5:0]     w_raw_n;
  logic [5:0]     w_accept;
  logic [1:0]     w_held;
  logic [5:0]     r_sync1_n;
  logic [5:0]     r_sync2_n;
  logic [5:0]     r_deb_n;
  logic [DCW-1:0] r_dcnt [6];
  logic [3:0]     r_press;
  logic [SCW-1:0] r_sc [2];
  logic [2:0]     r_cnt [2];
  logic [1:0]     r_hold_pls;

  assign w_raw_n = {bif.raw_test_n, bif.raw_reset_n, bif.raw_diversion_n,
                    bif.raw_hambre_n, bif.raw_energia_n, bif.raw_salud_n};

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < 6; i++) begin
      w_accept[i] = (r_sync2_n[i] != r_deb_n[i]) && (r_dcnt[i] == DC_LAST);
    end
  end

  assign w_held = ~r_deb_n[5:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1_n <= '1;
      r_sync2_n <= '1;
      r_deb_n   <= '1;
      r_press   <= '0;
      for (int i = 0; i < 6; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_sync1_n <= w_raw_n;
      r_sync2_n <= r_sync1_n;
      // Pulse lands in the same cycle the debounced level turns pressed.
      r_press   <= w_accept[3:0] & ~r_sync2_n[3:0];
      for (int i = 0; i < 6; i++) begin
        if (r_sync2_n[i] == r_deb_n[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_deb_n[i] <= r_sync2_n[i];
          r_dcnt[i]  <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_pls <= '0;
      for (int j = 0; j < 2; j++) begin
        r_sc[j]  <= '0;
        r_cnt[j] <= '0;
      end
    end else begin
      r_hold_pls <= '0;
      for (int j = 0; j < 2; j++) begin
        if (!w_held[j]) begin
          r_sc[j]  <= '0;
          r_cnt[j] <= '0;
        end else if (r_cnt[j] < HOLD_MAX) begin
          if (r_sc[j] == SC_LAST) begin
            r_sc[j]  <= '0;
            r_cnt[j] <= r_cnt[j] + 3'd1;
            // Test hold never fires while reset is held, so reset wins a tie.
            r_hold_pls[j] <= (r_cnt[j] + 3'd1 == HOLD_MAX) && ((j == 0) || r_deb_n[4]);
          end else begin
            r_sc[j] <= r_sc[j] + 1'b1;
          end
        end else begin
          r_sc[j] <= '0;
        end
      end
    end
  end

  assign bif.btn_salud     = r_press[0];
  assign bif.btn_energia   = r_press[1];
  assign bif.btn_hambre    = r_press[2];
  assign bif.btn_diversion = r_press[3];
  assign bif.btn_reset     = r_hold_pls[0];
  assign bif.btn_test      = r_hold_pls[1];
  assign bif.count_reset   = r_cnt[0];
  assign bif.count_test    = r_cnt[1];
endmodule

// File: tb/tb_tamagotchi_button_ctrl.sv
// Bench for tamagotchi_button_ctrl: cycle-by-cycle model comparison plus directed literal checks.
module tb_tamagotchi_button_ctrl;
  localparam int F  = 100;
  localparam int DC = 4;
  localparam int H  = 5;

  logic clk;
  logic rst_n;
  tamagotchi_button_ctrl_if bif();

  tamagotchi_button_ctrl #(.CLK_FREQ_HZ(F), .DEBOUNCE_CYCLES(DC), .HOLD_SEC(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Model: debounced level flips after DC consecutive disagreeing synced samples;
  // hold outputs derive from the number of cycles the debounced level has been pressed.
  logic [5:0] raw_v;
  assign raw_v = {bif.raw_test_n, bif.raw_reset_n, bif.raw_diversion_n,
                  bif.raw_hambre_n, bif.raw_energia_n, bif.raw_salud_n};

  bit [5:0] m_s1, m_s2, m_rel, os2, orel;
  int       m_run [6];
  int       m_held [2];
  bit [3:0] m_btn;
  bit       m_br, m_bt;

  function automatic int cnt_of(int h);
    return (h / F > H) ? H : h / F;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_rel = '1;
      m_btn = '0; m_br = 1'b0; m_bt = 1'b0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
      m_held[0] = 0; m_held[1] = 0;
    end else begin
      os2 = m_s2; orel = m_rel;
      m_btn = '0;
      for (int i = 0; i < 6; i++) begin
        if (os2[i] != orel[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_rel[i] = os2[i];
            m_run[i] = 0;
            if (i < 4 && !os2[i]) m_btn[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (!orel[4+j]) m_held[j] = (m_held[j] > H*F) ? H*F + 1 : m_held[j] + 1;
        else            m_held[j] = 0;
      end
      m_br = (m_held[0] == H*F);
      m_bt = (m_held[1] == H*F) && orel[4];
      m_s2 = m_s1;
      m_s1 = raw_v;
    end
  end

  // Pulse monitor and per-cycle compare, 1 time unit after each rising edge.
  int pc [6];
  int pe [6];
  logic [11:0] act_v, exp_v;
  always begin
    @(posedge clk);
    #1;
    act_v = {bif.btn_salud, bif.btn_energia, bif.btn_hambre, bif.btn_diversion,
             bif.btn_reset, bif.btn_test, bif.count_reset, bif.count_test};
    exp_v = {m_btn[0], m_btn[1], m_btn[2], m_btn[3], m_br, m_bt,
             3'(cnt_of(m_held[0])), 3'(cnt_of(m_held[1]))};
    n_total++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL model_cmp edge %0d: got %b expected %b", edge_cnt, act_v, exp_v);
    for (int i = 0; i < 6; i++) begin
      if (act_v[11-i]) begin
        pc[i]++;
        pe[i] = edge_cnt;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic to_edge(input int e);
    int guard = 0;
    while (edge_cnt < e && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("to_edge_reached", (edge_cnt >= e) ? 1 : 0, 1);
  endtask

  task automatic clr_pc();
    for (int i = 0; i < 6; i++) begin
      pc[i] = 0;
      pe[i] = -1;
    end
  endtask

  function automatic int outs_or();
    return int'({bif.btn_salud, bif.btn_energia, bif.btn_hambre, bif.btn_diversion,
                 bif.btn_reset, bif.btn_test, bif.count_reset, bif.count_test});
  endfunction

  int e0, r1;

  initial begin
    bif.raw_salud_n = 1'b1; bif.raw_energia_n = 1'b1; bif.raw_hambre_n = 1'b1;
    bif.raw_diversion_n = 1'b1; bif.raw_reset_n = 1'b1; bif.raw_test_n = 1'b1;
    rst_n = 1'b0;
    clr_pc();
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", outs_or(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Salud press: one pulse, 6 edges counting the first low sample.
    clr_pc();
    e0 = edge_cnt + 1;
    bif.raw_salud_n = 1'b0;
    to_edge(e0 + 30);
    check("salud_pulse_count", pc[0], 1);
    check("salud_pulse_edge", pe[0], e0 + 5);
    bif.raw_salud_n = 1'b1;
    to_edge(edge_cnt + 15);
    check("salud_no_release_pulse", pc[0], 1);

    // Hambre bounce: low3/high1/low3 gives nothing, then a stable press.
    clr_pc();
    bif.raw_hambre_n = 1'b0; repeat (3) @(negedge clk);
    bif.raw_hambre_n = 1'b1; repeat (1) @(negedge clk);
    bif.raw_hambre_n = 1'b0; repeat (3) @(negedge clk);
    bif.raw_hambre_n = 1'b1; repeat (10) @(negedge clk);
    check("hambre_bounce_no_pulse", pc[2], 0);
    e0 = edge_cnt + 1;
    bif.raw_hambre_n = 1'b0;
    to_edge(e0 + 12);
    check("hambre_stable_pulse", pc[2], 1);
    check("hambre_pulse_edge", pe[2], e0 + 5);
    bif.raw_hambre_n = 1'b1;
    to_edge(edge_cnt + 12);

    // Reset hold 600 cycles: seconds step every 100 cycles, one pulse at 5.
    clr_pc();
    e0 = edge_cnt + 1;
    bif.raw_reset_n = 1'b0;
    for (int k = 1; k <= H; k++) begin
      to_edge(e0 + 5 + 100*k - 1);
      check("count_reset_before_step", int'(bif.count_reset), k - 1);
      to_edge(e0 + 5 + 100*k);
      check("count_reset_step", int'(bif.count_reset), k);
    end
    to_edge(e0 + 600);
    check("count_reset_saturated", int'(bif.count_reset), 5);
    check("btn_reset_pulse_count", pc[4], 1);
    check("btn_reset_pulse_edge", pe[4], e0 + 505);
    r1 = edge_cnt + 1;
    bif.raw_reset_n = 1'b1;
    to_edge(r1 + 5);
    check("count_reset_held_until_debounced", int'(bif.count_reset), 5);
    to_edge(r1 + 6);
    check("count_reset_cleared", int'(bif.count_reset), 0);

    // Test held 499 cycles past its debounced press: reaches 4, never pulses.
    clr_pc();
    e0 = edge_cnt + 1;
    bif.raw_test_n = 1'b0;
    to_edge(e0 + 405);
    check("count_test_four", int'(bif.count_test), 4);
    to_edge(e0 + 498);
    bif.raw_test_n = 1'b1;
    to_edge(e0 + 504);
    check("count_test_last_held", int'(bif.count_test), 4);
    to_edge(e0 + 520);
    check("count_test_cleared", int'(bif.count_test), 0);
    check("btn_test_short_hold", pc[5], 0);

    // Simultaneous reset+test: reset wins the tie.
    clr_pc();
    e0 = edge_cnt + 1;
    bif.raw_reset_n = 1'b0; bif.raw_test_n = 1'b0;
    to_edge(e0 + 600);
    check("both_count_reset", int'(bif.count_reset), 5);
    check("both_count_test", int'(bif.count_test), 5);
    check("both_btn_reset", pc[4], 1);
    check("both_btn_test_suppressed", pc[5], 0);
    bif.raw_reset_n = 1'b1; bif.raw_test_n = 1'b1;
    to_edge(edge_cnt + 15);

    // rst_n mid-hold with the button still held: restart from zero.
    clr_pc();
    e0 = edge_cnt + 1;
    bif.raw_reset_n = 1'b0;
    to_edge(e0 + 305);
    check("pre_rst_count_reset", int'(bif.count_reset), 3);
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", outs_or(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = edge_cnt + 1;
    to_edge(e0 + 305);
    check("post_rst_count_reset", int'(bif.count_reset), 3);
    to_edge(e0 + 510);
    check("post_rst_btn_reset_count", pc[4], 1);
    check("post_rst_btn_reset_edge", pe[4], e0 + 505);
    bif.raw_reset_n = 1'b1;
    to_edge(edge_cnt + 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tamagotchi_button_ctrl.md
Name: tamagotchi_button_ctrl

Overview:
Front-end conditioner that drives the button inputs of tamagotchi_fsm.
- Takes the six raw, active-low, asynchronous push-buttons.
- Synchronises and debounces each one.
- Emits single-cycle press pulses for the four mode buttons.
- Measures hold time in whole seconds for reset/test and drives count_reset/count_test.
- Pulses btn_reset/btn_test only after a full HOLD_SEC hold.

Parameters:
CLK_FREQ_HZ, 50000000, clk cycles per second; hold-time prescaler terminal count.
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a level change (minimum 2).
HOLD_SEC, 5, seconds of hold before btn_reset/btn_test pulse (1..7; must fit the 3-bit counters).

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset; deassertion synchronous to clk
raw_salud_n  in  1  raw salud button, 0 = pressed, asynchronous
raw_energia_n  in  1  raw energia button, 0 = pressed
raw_hambre_n  in  1  raw hambre button, 0 = pressed
raw_diversion_n  in  1  raw diversion button, 0 = pressed
raw_reset_n  in  1  raw reset button, 0 = pressed
raw_test_n  in  1  raw test button, 0 = pressed
btn_salud  out  1  1-cycle pulse on debounced press
btn_energia  out  1  1-cycle pulse on debounced press
btn_hambre  out  1  1-cycle pulse on debounced press
btn_diversion  out  1  1-cycle pulse on debounced press
btn_reset  out  1  1-cycle pulse when reset hold reaches HOLD_SEC
btn_test  out  1  1-cycle pulse when test hold reaches HOLD_SEC
count_reset  out  3  whole seconds reset has been held, saturating at HOLD_SEC
count_test  out  3  whole seconds test has been held, saturating at HOLD_SEC

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops load 1 (released); debounced state = released.
  - All debounce, prescaler and hold counters = 0.
  - All outputs = 0.
- Synchronisation: each raw input passes through 2 flops; the output is s.
- Debounce, per button (debounced level d, counter c):
  - if s==d: c<=0.
  - else if c==DEBOUNCE_CYCLES-1: d<=s, c<=0.
  - else: c<=c+1.
  - So d changes only after DEBOUNCE_CYCLES consecutive cycles of s!=d; any glitch back to d clears c.
- Press pulse (mode buttons):
  - Registered high for exactly one cycle, the same cycle d goes released->pressed.
  - Latency from the first clk edge sampling raw low = DEBOUNCE_CYCLES+2 edges.
  - Release produces no pulse.
  - One pulse per press however long held; no auto-repeat.
  - Buttons are independent; simultaneous presses give simultaneous pulses.
- Hold timer, reset and test independently (prescaler sc, seconds cnt):
  - d released: sc<=0, cnt<=0 on the next edge; no pulse.
  - d pressed and cnt<HOLD_SEC: sc increments each cycle.
  - At sc==CLK_FREQ_HZ-1: sc<=0 and cnt<=cnt+1.
  - If that increment makes cnt==HOLD_SEC, the matching btn_reset/btn_test pulses for that one cycle.
  - cnt==HOLD_SEC: saturate; sc held at 0; no further pulses until release and re-press.
  - Timing: counting starts the cycle after d becomes pressed, so the pulse fires HOLD_SEC*CLK_FREQ_HZ cycles after the debounced press edge.
  - count_reset/count_test output cnt directly (registered).
- Simultaneous reset+test holds:
  - Both counters run and both count_* outputs are valid.
  - If both reach HOLD_SEC in the same cycle, only btn_reset pulses; btn_test is suppressed for that press.
  - btn_test never pulses while the reset debounced level is pressed.
- Reset mid-operation:
  - Any partial count or pulse is aborted immediately.
  - A button still held after rst_n deassertion is treated as a new press: pulse after debounce, hold count restarts from 0.
- Widths:
  - sc is ceil(log2(CLK_FREQ_HZ)) bits.
  - c is ceil(log2(DEBOUNCE_CYCLES)) bits.
  - No counter may wrap; all saturate or clear as specified.

Test Plan (CLK_FREQ_HZ=100, DEBOUNCE_CYCLES=4, HOLD_SEC=5):
- raw_salud_n low and held -> btn_salud high exactly one cycle, 6 edges after the first low sample; no further pulse while held or on release.
- raw_hambre_n bounces low 3 cycles / high 1 / low 3 -> no pulse; then low for 4+ stable cycles -> one pulse.
- raw_reset_n held 600 cycles -> count_reset steps 1..5 at 100-cycle intervals, btn_reset one pulse when count reaches 5, count stays 5; release -> count_reset=0 after debounce+1.
- raw_test_n held exactly 499 cycles after the debounced press, then released -> count_test reaches 4, btn_test never asserted.
- raw_reset_n and raw_test_n pressed in the same cycle, held 600 cycles -> both counts reach 5, btn_reset pulses once, btn_test stays 0.
- rst_n pulsed low at count_reset=3 while raw_reset_n stays low -> all outputs 0 immediately; after release, count restarts from 0 and btn_reset pulses 500 cycles after the new debounced press.
